bubsys_sram_arbiter: RTL and testbench
======================================

# bubsys_sram_arbiter

Two-port arbiter that shares one single-port work SRAM (1-cycle registered read, write wins over read) between the bubble-transfer DMA engine (requester 0) and the 68000 CPU bus interface (requester 1). It accepts a request/acknowledge transaction from each side and drives a single set of SRAM strobes. Read data returns to the requester that issued the read, with a valid pulse. It sits between the two bus masters and the SRAM instance in the BubSys memory subsystem.

## Interface
- AW, 10, SRAM address width
- DW, 8, SRAM data width
- i_MCLK  in  1  master clock; all logic on rising edge
- i_RST  in  1  reset, synchronous, active-high
- i_R0_REQ, i_R1_REQ  in  1  access request, held until ACK sampled
- i_R0_WE, i_R1_WE  in  1  1 = write, 0 = read; qualified by REQ
- i_R0_ADDR, i_R1_ADDR  in  AW  access address
- i_R0_DIN, i_R1_DIN  in  DW  write data
- o_R0_ACK, o_R1_ACK  out  1  one-cycle grant pulse
- o_R0_DOUT, o_R1_DOUT  out  DW  read data, held until that requester's next read completes
- o_R0_DVALID, o_R1_DVALID  out  1  one-cycle read-data-valid pulse
- o_SRAM_ADDR  out  AW  to SRAM address
- o_SRAM_DIN  out  DW  to SRAM write data
- o_SRAM_RD  out  1  SRAM read strobe
- o_SRAM_WR  out  1  SRAM write strobe
- i_SRAM_DOUT  in  DW  SRAM registered read data

## Operation
- FSM has two states. In IDLE, no strobes are driven. In GRANT, the strobes and the ACK for the winner are driven for exactly one cycle, then the FSM always returns to IDLE.
- IDLE -> GRANT on any sampled REQ; winner, WE, ADDR and DIN are registered at that edge.
- GRANT: o_SRAM_WR = WE, o_SRAM_RD = !WE; the two are never high together. o_Rn_ACK = 1 for the winner only.
- Mandatory IDLE cycle after every GRANT. The requester drops or changes REQ after seeing ACK, and a held REQ is not re-granted.
- Read return uses a 2-stage pending pipeline {valid, owner}. The stage-2 edge loads i_SRAM_DOUT into o_owner_DOUT and pulses o_owner_DVALID.
- Arbitration when both REQ are high in IDLE: see Configuration. A single requester always wins.
- Last-grant pointer `last` is updated on every grant.
- Reset (any cycle, including mid-GRANT or with a read in flight):
  - FSM goes to IDLE and the pipeline is cleared.
  - All o_* are 0, including DOUTs.
  - `last` = 1, so the first contended grant goes to R0.
  - An in-flight read produces no DVALID.
- o_SRAM_ADDR/o_SRAM_DIN hold the last granted values while in IDLE; they are 0 after reset.

## Timing
- Edge E samples REQ in IDLE. During cycle E..E+1: ACK and strobes high.
- SRAM acts at edge E+1. For a read, i_SRAM_DOUT is valid after E+1.
- Edge E+2 captures the data. DVALID is high and DOUT is valid during E+2..E+3.
- Read latency is REQ-sample to DVALID = 2 cycles. Write completes at edge E+1.
- Peak throughput is one access per 2 cycles. Read pipelines overlap, so back-to-back reads give DVALIDs 2 cycles apart.
- A write to address A granted before a read of A returns the new data.

## Configuration
- BUBSYS_SRAM_ARB_RR_EN defined: round-robin. On contention, the requester != `last` wins.
- Not defined: fixed priority. R0 (DMA) always wins contention and `last` is unused. R1 can starve while R0 requests continuously; this is intended, because DMA transfers have a hard deadline.

## Test plan
- R1 read: REQ at A=0x155 (SRAM holds 0x3C) -> R1_ACK 1 cycle later, SRAM_RD for 1 cycle, R1_DVALID with DOUT=0x3C 2 cycles after REQ sample; R0 outputs unchanged.
- R0 write: 0xA5 to 0x3FF, then R1 read of 0x3FF -> R1_DOUT=0xA5; SRAM_WR exactly 1 cycle, never overlapping SRAM_RD.
- Both REQ held high continuously, 8 grants:
  - With BUBSYS_SRAM_ARB_RR_EN: ACKs alternate R0,R1,R0,..., one every 2 cycles.
  - Without it: all 8 go to R0 and R1_ACK stays 0.
- Held REQ: R0 keeps REQ high for 1 cycle after ACK -> no second grant is issued during the mandatory IDLE cycle.
- Reset mid-read: assert i_RST on the cycle after an R1 read's ACK -> no R1_DVALID, all outputs 0 the next cycle, first contended grant afterwards goes to R0.

Source files
------------

// File: rtl/bubsys_sram_arbiter.sv
// Shares one single-port work SRAM between the bubble DMA (R0) and the CPU (R1).
// Define BUBSYS_SRAM_ARB_RR_EN for round-robin contention; default is fixed R0 priority.
`timescale 1ns/1ps
module bubsys_sram_arbiter #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          i_MCLK,
  input  logic          i_RST,
  input  logic          i_R0_REQ,
  input  logic          i_R0_WE,
  input  logic [AW-1:0] i_R0_ADDR,
  input  logic [DW-1:0] i_R0_DIN,
  output logic          o_R0_ACK,
  output logic [DW-1:0] o_R0_DOUT,
  output logic          o_R0_DVALID,
  input  logic          i_R1_REQ,
  input  logic          i_R1_WE,
  input  logic [AW-1:0] i_R1_ADDR,
  input  logic [DW-1:0] i_R1_DIN,
  output logic          o_R1_ACK,
  output logic [DW-1:0] o_R1_DOUT,
  output logic          o_R1_DVALID,
  output logic [AW-1:0] o_SRAM_ADDR,
  output logic [DW-1:0] o_SRAM_DIN,
  output logic          o_SRAM_RD,
  output logic          o_SRAM_WR,
  input  logic [DW-1:0] i_SRAM_DOUT
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  logic req_any;
  logic win_nx;
  logic win;
  logic we_q;
  logic p1_vld;
  logic p1_own;
  logic take;

  assign req_any = i_R0_REQ | i_R1_REQ;
  assign take    = (state == S_IDLE) & req_any;

`ifdef BUBSYS_SRAM_ARB_RR_EN
  logic last;

  always_comb begin
    if (i_R0_REQ & i_R1_REQ) win_nx = ~last;
    else                     win_nx = ~i_R0_REQ;
  end

  always_ff @(posedge i_MCLK) begin
    if (i_RST)     last <= 1'b1;
    else if (take) last <= win_nx;
  end
`else
  // DMA has a hard deadline, so R0 always wins contention
  always_comb begin
    win_nx = ~i_R0_REQ;
  end
`endif

  always_ff @(posedge i_MCLK) begin
    if (i_RST) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (req_any) state_nx = S_GRANT;
      S_GRANT: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    o_R0_ACK  = 1'b0;
    o_R1_ACK  = 1'b0;
    o_SRAM_WR = 1'b0;
    o_SRAM_RD = 1'b0;
    if (state == S_GRANT) begin
      o_R0_ACK  = ~win;
      o_R1_ACK  = win;
      o_SRAM_WR = we_q;
      o_SRAM_RD = ~we_q;
    end
  end

  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      win         <= 1'b0;
      we_q        <= 1'b0;
      o_SRAM_ADDR <= '0;
      o_SRAM_DIN  <= '0;
    end else if (take) begin
      win         <= win_nx;
      we_q        <= win_nx ? i_R1_WE   : i_R0_WE;
      o_SRAM_ADDR <= win_nx ? i_R1_ADDR : i_R0_ADDR;
      o_SRAM_DIN  <= win_nx ? i_R1_DIN  : i_R0_DIN;
    end
  end

  // Stage 1 tracks the SRAM read edge, stage 2 lands data in the owner
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      p1_vld      <= 1'b0;
      p1_own      <= 1'b0;
      o_R0_DVALID <= 1'b0;
      o_R1_DVALID <= 1'b0;
      o_R0_DOUT   <= '0;
      o_R1_DOUT   <= '0;
    end else begin
      p1_vld      <= o_SRAM_RD;
      p1_own      <= win;
      o_R0_DVALID <= p1_vld & ~p1_own;
      o_R1_DVALID <= p1_vld & p1_own;
      if (p1_vld & ~p1_own) o_R0_DOUT <= i_SRAM_DOUT;
      if (p1_vld & p1_own)  o_R1_DOUT <= i_SRAM_DOUT;
    end
  end

endmodule

// File: tb/tb_bubsys_sram_arbiter.sv
// Randomized bench for bubsys_sram_arbiter against a transaction-level model.
// Works with or without BUBSYS_SRAM_ARB_RR_EN defined.
`timescale 1ns/1ps
module tb_bubsys_sram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       req  [2];
  logic       we   [2];
  logic [9:0] addr [2];
  logic [7:0] din  [2];

  logic       ack0, ack1, dv0, dv1;
  logic [7:0] dout0, dout1;
  logic [9:0] s_addr;
  logic [7:0] s_din;
  logic       s_rd, s_wr;
  logic [7:0] s_dout = 8'h00;

  logic [7:0] sram [1024];

  always #5 clk = ~clk;

  bubsys_sram_arbiter #(.AW(10), .DW(8)) dut (
    .i_MCLK      (clk),
    .i_RST       (rst),
    .i_R0_REQ    (req[0]),
    .i_R0_WE     (we[0]),
    .i_R0_ADDR   (addr[0]),
    .i_R0_DIN    (din[0]),
    .o_R0_ACK    (ack0),
    .o_R0_DOUT   (dout0),
    .o_R0_DVALID (dv0),
    .i_R1_REQ    (req[1]),
    .i_R1_WE     (we[1]),
    .i_R1_ADDR   (addr[1]),
    .i_R1_DIN    (din[1]),
    .o_R1_ACK    (ack1),
    .o_R1_DOUT   (dout1),
    .o_R1_DVALID (dv1),
    .o_SRAM_ADDR (s_addr),
    .o_SRAM_DIN  (s_din),
    .o_SRAM_RD   (s_rd),
    .o_SRAM_WR   (s_wr),
    .i_SRAM_DOUT (s_dout)
  );

  // Single-port SRAM with registered read
  always @(posedge clk) begin
    if (s_wr) sram[s_addr] <= s_din;
    else if (s_rd) s_dout <= sram[s_addr];
  end

  typedef struct {
    int         due;
    bit         own;
    logic [7:0] data;
  } rd_t;

  rd_t        q [$];
  logic [7:0] refmem [1024];
  int         cyc = 0;
  int         next_ok = 0;
  bit         last = 1'b1;
  bit         e_ack [2];
  bit         e_dv  [2];
  logic [7:0] e_dout [2];
  bit         e_rd, e_wr;
  logic [9:0] e_addr;
  logic [7:0] e_din;

  bit hold   [2];
  bit dpend  [2];
  bit sticky [2];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    int  w;
    rd_t t;
    if (rst) begin
      q.delete();
      next_ok = cyc + 1;
      last    = 1'b1;
      e_ack   = '{0, 0};
      e_dv    = '{0, 0};
      e_dout  = '{8'h00, 8'h00};
      e_rd    = 1'b0;
      e_wr    = 1'b0;
      e_addr  = '0;
      e_din   = '0;
      return;
    end
    e_ack = '{0, 0};
    e_dv  = '{0, 0};
    e_rd  = 1'b0;
    e_wr  = 1'b0;
    if ((req[0] || req[1]) && cyc >= next_ok) begin
      if (req[0] && req[1]) begin
`ifdef BUBSYS_SRAM_ARB_RR_EN
        w = last ? 0 : 1;
`else
        w = 0;
`endif
      end else begin
        w = req[0] ? 0 : 1;
      end
      e_ack[w] = 1'b1;
      e_addr   = addr[w];
      e_din    = din[w];
      if (we[w]) begin
        e_wr = 1'b1;
        refmem[addr[w]] = din[w];
      end else begin
        e_rd   = 1'b1;
        t.due  = cyc + 2;
        t.own  = w[0];
        t.data = refmem[addr[w]];
        q.push_back(t);
      end
      last    = w[0];
      next_ok = cyc + 2;
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      e_dv[q[0].own]   = 1'b1;
      e_dout[q[0].own] = q[0].data;
      void'(q.pop_front());
    end
  endtask

  task automatic compare();
    chk("ack0",   32'(ack0),   32'(e_ack[0]));
    chk("ack1",   32'(ack1),   32'(e_ack[1]));
    chk("rd",     32'(s_rd),   32'(e_rd));
    chk("wr",     32'(s_wr),   32'(e_wr));
    chk("addr",   32'(s_addr), 32'(e_addr));
    chk("sdin",   32'(s_din),  32'(e_din));
    chk("dv0",    32'(dv0),    32'(e_dv[0]));
    chk("dv1",    32'(dv1),    32'(e_dv[1]));
    chk("dout0",  32'(dout0),  32'(e_dout[0]));
    chk("dout1",  32'(dout1),  32'(e_dout[1]));
  endtask

  task automatic agents();
    for (int r = 0; r < 2; r++) begin
      if (dpend[r]) begin
        req[r]   = 1'b0;
        dpend[r] = 1'b0;
      end else if (e_ack[r] && !sticky[r]) begin
        if (hold[r]) begin
          hold[r]  = 1'b0;
          dpend[r] = 1'b1;
        end else begin
          req[r] = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare();
    agents();
  endtask

  task automatic issue(input int r, input bit w,
                       input logic [9:0] a,
                       input logic [7:0] d);
    req[r]  = 1'b1;
    we[r]   = w;
    addr[r] = a;
    din[r]  = d;
  endtask

  int n0, n1;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram[i]   = 8'($urandom);
      refmem[i] = sram[i];
    end
    sram[10'h155]   = 8'h3C;
    refmem[10'h155] = 8'h3C;
    for (int r = 0; r < 2; r++) begin
      req[r] = 1'b0; we[r] = 1'b0;
      addr[r] = '0;  din[r] = '0;
      hold[r] = 0; dpend[r] = 0; sticky[r] = 0;
    end
    #2;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    issue(1, 1'b0, 10'h155, 8'h00);
    repeat (4) step();
    chk("r1_read", 32'(dout1), 32'h3C);

    issue(0, 1'b1, 10'h3FF, 8'hA5);
    repeat (3) step();
    issue(1, 1'b0, 10'h3FF, 8'h00);
    repeat (4) step();
    chk("wr_rd", 32'(dout1), 32'hA5);

    sticky = '{1, 1};
    issue(0, 1'b0, 10'h010, 8'h00);
    issue(1, 1'b0, 10'h020, 8'h00);
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      n0 += int'(ack0);
      n1 += int'(ack1);
    end
`ifdef BUBSYS_SRAM_ARB_RR_EN
    chk("cont_n0", 32'(n0), 32'd4);
    chk("cont_n1", 32'(n1), 32'd4);
`else
    chk("cont_n0", 32'(n0), 32'd8);
    chk("cont_n1", 32'(n1), 32'd0);
`endif
    sticky = '{0, 0};
    req    = '{1'b0, 1'b0};
    repeat (3) step();

    issue(0, 1'b0, 10'h155, 8'h00);
    hold[0] = 1'b1;
    repeat (5) step();

    issue(1, 1'b0, 10'h155, 8'h00);
    step();
    step();
    rst = 1'b1;
    step();
    chk("rst_dout1", 32'(dout1), 32'h00);
    rst = 1'b0;
    step();
    issue(0, 1'b0, 10'h001, 8'h00);
    issue(1, 1'b0, 10'h002, 8'h00);
    step();
    chk("post_rst_win", 32'(ack0), 32'd1);
    repeat (6) step();

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (rst) begin
        req   = '{1'b0, 1'b0};
        hold  = '{0, 0};
        dpend = '{0, 0};
      end else begin
        for (int r = 0; r < 2; r++) begin
          if (!req[r] && !dpend[r] && $urandom_range(0, 2) == 0) begin
            issue(r, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 10'h3FF
                  : 10'($urandom_range(0, 15)),
                  8'($urandom));
            hold[r] = ($urandom_range(0, 3) == 0);
          end
        end
      end
      step();
    end
    rst = 1'b0;
    req = '{1'b0, 1'b0};
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
